// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single SDRAM controller slave.
// Requester 0 (sample capture) and requester 1 (Nios bridge) share the port
// one command at a time, with a round-robin tie break. An in-order FIFO of
// requester ids routes each read response back to the port that issued it.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int PEND_DEPTH = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [ADDR_W-1:0]             s0_address,
  input  logic                          s0_read,
  input  logic                          s0_write,
  input  logic [DATA_W-1:0]             s0_writedata,
  input  logic [DATA_W/8-1:0]           s0_byteenable,
  output logic                          s0_waitrequest,
  output logic [DATA_W-1:0]             s0_readdata,
  output logic                          s0_readdatavalid,
  input  logic [ADDR_W-1:0]             s1_address,
  input  logic                          s1_read,
  input  logic                          s1_write,
  input  logic [DATA_W-1:0]             s1_writedata,
  input  logic [DATA_W/8-1:0]           s1_byteenable,
  output logic                          s1_waitrequest,
  output logic [DATA_W-1:0]             s1_readdata,
  output logic                          s1_readdatavalid,
  output logic [ADDR_W-1:0]             m_address,
  output logic [DATA_W-1:0]             m_writedata,
  output logic [DATA_W/8-1:0]           m_byteenable,
  output logic                          m_read,
  output logic                          m_write,
  input  logic                          m_waitrequest,
  input  logic [DATA_W-1:0]             m_readdata,
  input  logic                          m_readdatavalid,
  output logic [$clog2(PEND_DEPTH):0]   pend_count,
  output logic                          err_orphan
);

  localparam int PTR_W = $clog2(PEND_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(PEND_DEPTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  g_read, g_write;
  logic                  req0, req1;
  logic                  pop, push, full, full_eff, read_blocked, accept;
  logic [PEND_DEPTH-1:0] id_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      pend_count_q, pend_count_d;
  logic                  err_orphan_q;
  logic                  head_id;

  assign req0    = s0_read | s0_write;
  assign req1    = s1_read | s1_write;
  assign g_read  = grant_q ? s1_read  : s0_read;
  assign g_write = grant_q ? s1_write : s0_write;

  // A response only pops when an id is outstanding; during reset nothing pops.
  assign head_id  = id_q[rd_ptr_q];
  assign pop      = reset_reset_n & m_readdatavalid & (pend_count_q != '0);
  assign full     = (pend_count_q == DEPTH_CNT);
  // A same-cycle pop frees a slot, so a full-blocked read may go out now.
  assign full_eff = full & ~pop;
  assign read_blocked = g_read & ~g_write & full_eff;

  assign accept = (m_read | m_write) & ~m_waitrequest;
  assign push   = m_read & ~m_waitrequest;

  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = pop & ~head_id;
  assign s1_readdatavalid = pop & head_id;
  assign pend_count       = pend_count_q;
  assign err_orphan       = err_orphan_q;

  // State register: arbitration state, current grant and last-served port.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: pick a requester in IDLE, return to IDLE on accept or abandon.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) grant_d = ~last_q;
          else              grant_d = req1;
          last_d  = grant_d;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept || !(g_read || g_write)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: forward the granted port's command and stall everyone else.
  always_comb begin
    m_address      = grant_q ? s1_address    : s0_address;
    m_writedata    = grant_q ? s1_writedata  : s0_writedata;
    m_byteenable   = grant_q ? s1_byteenable : s0_byteenable;
    m_read         = 1'b0;
    m_write        = 1'b0;
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    if (reset_reset_n && state_q == BUSY) begin
      m_write = g_write;
      m_read  = g_read & ~g_write & ~full_eff;
      if (grant_q) s1_waitrequest = m_waitrequest | read_blocked;
      else         s0_waitrequest = m_waitrequest | read_blocked;
    end
  end

  // Occupancy of the outstanding-read FIFO.
  always_comb begin
    pend_count_d = pend_count_q;
    case ({push, pop})
      2'b10:   pend_count_d = pend_count_q + CNT_W'(1);
      2'b01:   pend_count_d = pend_count_q - CNT_W'(1);
      default: pend_count_d = pend_count_q;
    endcase
  end

  // FIFO pointers, count and the sticky orphan-response flag.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_count_q <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      pend_count_q <= pend_count_d;
      if (m_readdatavalid && pend_count_q == '0) err_orphan_q <= 1'b1;
    end
  end

  // Id storage; stale entries are harmless because the pointers gate them.
  always_ff @(posedge clk_clk) begin
    if (push) id_q[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: arbitration, stalls, full FIFO,
// response routing, orphan detection and reset behaviour.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int PEND_DEPTH = 4;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [ADDR_W-1:0] s0_address, s1_address, m_address;
  logic              s0_read, s0_write, s1_read, s1_write;
  logic [DATA_W-1:0] s0_writedata, s1_writedata, m_writedata;
  logic [1:0]        s0_byteenable, s1_byteenable, m_byteenable;
  logic              s0_waitrequest, s1_waitrequest;
  logic [DATA_W-1:0] s0_readdata, s1_readdata, m_readdata;
  logic              s0_readdatavalid, s1_readdatavalid;
  logic              m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [2:0]        pend_count;
  logic              err_orphan;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_DEPTH(PEND_DEPTH)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .pend_count(pend_count), .err_orphan(err_orphan)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Issue one read from a port with no controller stall: IDLE, BUSY, back to IDLE.
  task automatic do_read(input int port);
    if (port == 0) s0_read = 1'b1; else s1_read = 1'b1;
    tick();
    tick();
    s0_read = 1'b0;
    s1_read = 1'b0;
    settle();
    $display("read issued from port %0d, pend_count %0d", port, pend_count);
  endtask

  initial begin
    reset_reset_n   = 1'b0;
    s0_address = '0; s1_address = '0;
    s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s0_writedata = '0; s1_writedata = '0;
    s0_byteenable = 2'b11; s1_byteenable = 2'b11;
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;

    // Reset state, with a request and a stray response held during reset.
    tick();
    tick();
    s0_read = 1'b1;
    m_readdatavalid = 1'b1;
    settle();
    check("rst_m_read", 32'(m_read), 32'h0);
    check("rst_m_write", 32'(m_write), 32'h0);
    check("rst_s0_wait", 32'(s0_waitrequest), 32'h1);
    check("rst_s1_wait", 32'(s1_waitrequest), 32'h1);
    check("rst_s0_rdv", 32'(s0_readdatavalid), 32'h0);
    check("rst_pend", 32'(pend_count), 32'h0);
    tick();
    check("rst_err", 32'(err_orphan), 32'h0);
    s0_read = 1'b0;
    m_readdatavalid = 1'b0;
    $display("reset state checked");

    // Both ports write on the first cycle after reset: port 0, then port 1.
    reset_reset_n = 1'b1;
    s0_address = 25'h10;  s0_writedata = 16'h1111; s0_write = 1'b1;
    s1_address = 25'h20;  s1_writedata = 16'h2222; s1_write = 1'b1;
    settle();
    check("tie_c0_m_write", 32'(m_write), 32'h0);
    tick();
    check("tie_c1_m_write", 32'(m_write), 32'h1);
    check("tie_c1_addr", 32'(m_address), 32'h10);
    check("tie_c1_data", 32'(m_writedata), 32'h1111);
    check("tie_c1_s0_wait", 32'(s0_waitrequest), 32'h0);
    check("tie_c1_s1_wait", 32'(s1_waitrequest), 32'h1);
    tick();
    s0_write = 1'b0;
    settle();
    check("tie_c2_m_write", 32'(m_write), 32'h0);
    tick();
    check("tie_c3_m_write", 32'(m_write), 32'h1);
    check("tie_c3_addr", 32'(m_address), 32'h20);
    check("tie_c3_data", 32'(m_writedata), 32'h2222);
    check("tie_c3_s1_wait", 32'(s1_waitrequest), 32'h0);
    $display("tie writes: port 0 then port 1 accepted");
    // Second tie: last was port 1, so port 0 wins again.
    tick();
    s0_write = 1'b1;
    settle();
    tick();
    check("tie2_addr", 32'(m_address), 32'h10);
    check("tie2_s0_wait", 32'(s0_waitrequest), 32'h0);
    tick();
    s0_write = 1'b0;
    s1_write = 1'b0;
    tick();
    $display("second tie: port 0 accepted");

    // Port 1 read stalled by the controller for three cycles.
    s1_address = 25'h0000123;
    s1_read = 1'b1;
    m_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("stall_m_read", 32'(m_read), 32'h1);
      check("stall_s1_wait", 32'(s1_waitrequest), 32'h1);
      check("stall_addr", 32'(m_address), 32'h123);
      tick();
    end
    m_waitrequest = 1'b0;
    settle();
    check("stall_rel_m_read", 32'(m_read), 32'h1);
    check("stall_rel_s1_wait", 32'(s1_waitrequest), 32'h0);
    check("stall_rel_pend", 32'(pend_count), 32'h0);
    tick();
    s1_read = 1'b0;
    settle();
    check("stall_done_pend", 32'(pend_count), 32'h1);
    check("stall_done_m_read", 32'(m_read), 32'h0);
    m_readdatavalid = 1'b1;
    m_readdata = 16'h5A5A;
    settle();
    check("rsp1_s1_rdv", 32'(s1_readdatavalid), 32'h1);
    check("rsp1_s0_rdv", 32'(s0_readdatavalid), 32'h0);
    check("rsp1_s1_data", 32'(s1_readdata), 32'h5A5A);
    check("rsp1_s0_data", 32'(s0_readdata), 32'h5A5A);
    tick();
    m_readdatavalid = 1'b0;
    settle();
    check("rsp1_pend", 32'(pend_count), 32'h0);
    $display("stalled port 1 read and its response");

    // Five back-to-back reads from port 0: four fill the FIFO, fifth blocks.
    s0_read = 1'b1;
    s0_address = 25'h100;
    for (int i = 0; i < 8; i++) tick();
    check("full_pend", 32'(pend_count), 32'h4);
    tick();
    check("full_m_read", 32'(m_read), 32'h0);
    check("full_s0_wait", 32'(s0_waitrequest), 32'h1);
    tick();
    check("full_hold_m_read", 32'(m_read), 32'h0);
    m_readdatavalid = 1'b1;
    m_readdata = 16'h0001;
    settle();
    check("full_pop_m_read", 32'(m_read), 32'h1);
    check("full_pop_s0_wait", 32'(s0_waitrequest), 32'h0);
    check("full_pop_s0_rdv", 32'(s0_readdatavalid), 32'h1);
    tick();
    m_readdatavalid = 1'b0;
    s0_read = 1'b0;
    settle();
    check("full_pop_pend", 32'(pend_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1'b1;
      settle();
      check("drain_s0_rdv", 32'(s0_readdatavalid), 32'h1);
      tick();
    end
    m_readdatavalid = 1'b0;
    settle();
    check("drain_pend", 32'(pend_count), 32'h0);
    $display("full FIFO: fifth read issued on pop, drained");

    // Interleaved reads s0, s1, s0 and in-order responses.
    do_read(0);
    do_read(1);
    do_read(0);
    check("ilv_pend", 32'(pend_count), 32'h3);
    begin
      logic [15:0] rsp_data [3];
      logic        rsp_port [3];
      rsp_data[0] = 16'hAAAA; rsp_port[0] = 1'b0;
      rsp_data[1] = 16'hBBBB; rsp_port[1] = 1'b1;
      rsp_data[2] = 16'hCCCC; rsp_port[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_readdatavalid = 1'b1;
        m_readdata = rsp_data[i];
        settle();
        check("ilv_s0_rdv", 32'(s0_readdatavalid), 32'(!rsp_port[i]));
        check("ilv_s1_rdv", 32'(s1_readdatavalid), 32'(rsp_port[i]));
        check("ilv_data", 32'(rsp_port[i] ? s1_readdata : s0_readdata), 32'(rsp_data[i]));
        $display("response %0h routed", rsp_data[i]);
        tick();
      end
    end
    m_readdatavalid = 1'b0;

    // Read and write together: write wins, no id pushed.
    s1_read = 1'b1; s1_write = 1'b1; s1_address = 25'h55;
    tick();
    check("rw_m_write", 32'(m_write), 32'h1);
    check("rw_m_read", 32'(m_read), 32'h0);
    tick();
    s1_read = 1'b0; s1_write = 1'b0;
    settle();
    check("rw_pend", 32'(pend_count), 32'h0);
    $display("read+write resolved as write");

    // Granted port abandons its command while stalled.
    s0_write = 1'b1;
    m_waitrequest = 1'b1;
    tick();
    s0_write = 1'b0;
    settle();
    check("drop_m_write", 32'(m_write), 32'h0);
    tick();
    m_waitrequest = 1'b0;
    s1_write = 1'b1;
    settle();
    check("drop_idle_s1_wait", 32'(s1_waitrequest), 32'h1);
    tick();
    check("drop_next_grant", 32'(s1_waitrequest), 32'h0);
    tick();
    s1_write = 1'b0;
    tick();
    $display("abandoned command returned to idle");

    // Orphan response with nothing outstanding.
    m_readdatavalid = 1'b1;
    settle();
    check("orph_s0_rdv", 32'(s0_readdatavalid), 32'h0);
    check("orph_s1_rdv", 32'(s1_readdatavalid), 32'h0);
    check("orph_pre_err", 32'(err_orphan), 32'h0);
    tick();
    m_readdatavalid = 1'b0;
    settle();
    check("orph_err", 32'(err_orphan), 32'h1);
    check("orph_pend", 32'(pend_count), 32'h0);
    tick();
    tick();
    check("orph_sticky", 32'(err_orphan), 32'h1);
    $display("orphan response flagged");

    // Reset with two reads outstanding, then two late responses.
    do_read(0);
    do_read(1);
    check("rst2_pend_before", 32'(pend_count), 32'h2);
    reset_reset_n = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    settle();
    check("rst2_pend", 32'(pend_count), 32'h0);
    check("rst2_err_clr", 32'(err_orphan), 32'h0);
    check("rst2_s0_wait", 32'(s0_waitrequest), 32'h1);
    check("rst2_s1_wait", 32'(s1_waitrequest), 32'h1);
    m_readdatavalid = 1'b1;
    settle();
    check("late_s0_rdv", 32'(s0_readdatavalid), 32'h0);
    check("late_s1_rdv", 32'(s1_readdatavalid), 32'h0);
    tick();
    tick();
    m_readdatavalid = 1'b0;
    settle();
    check("late_err", 32'(err_orphan), 32'h1);
    check("late_pend", 32'(pend_count), 32'h0);
    $display("late responses after reset flagged");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
